frame_bank_scheduler: RTL and testbench

Sequences the two on-chip frame banks as a ping-pong pair between the frame writer (decoded pixel stream) and the VGA display reader. Only the back bank accepts writes. The banks swap only when the back bank holds a complete frame and the display signals a frame boundary. Sits between the frame decoder, the two bank RAMs and the VGA timing block, in the CLK_40 domain.

---
 rtl/frame_bank_if.sv | 10 +
 rtl/frame_bank_scheduler.sv | 127 ++++++++++++
 tb/tb_frame_bank_scheduler.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/frame_bank_if.sv
// Writer-side pixel handshake between the frame decoder and the bank scheduler.
`timescale 1ns/1ps
interface frame_bank_if;
    logic wr_valid;
    logic wr_data;
    logic wr_ready;

    modport master (output wr_valid, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_data, output wr_ready);
endinterface

// File: rtl/frame_bank_scheduler.sv
// Ping-pong scheduler for two frame banks: the writer fills the back bank, and the
// banks swap only at a display frame boundary once the back frame is complete.
`timescale 1ns/1ps
module frame_bank_scheduler #(
    parameter int PIXELS_PER_FRAME = 1280,
    parameter int ADDR_W           = 11,
    parameter int DROP_W           = 8
) (
    input  logic              CLK_40,
    input  logic              reset,
    input  logic              init,
    frame_bank_if.slave       wr,
    input  logic              rd_frame_start,
    output logic              wr_en_b1,
    output logic              wr_en_b2,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              wr_data_q,
    output logic              rd_bank_sel,
    output logic              display_valid,
    output logic              frame_swap,
    output logic [DROP_W-1:0] dropped_frames
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_FILL = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;

    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(PIXELS_PER_FRAME - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              data_q, data_d;
    logic              wen_b1_q, wen_b1_d;
    logic              wen_b2_q, wen_b2_d;
    logic              sel_q, sel_d;
    logic              dv_q, dv_d;
    logic              swap_q, swap_d;
    logic [DROP_W-1:0] drop_q, drop_d;

    logic xfer;

    assign wr.wr_ready = (state_q == S_FILL);
    assign xfer        = wr.wr_valid && (state_q == S_FILL);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wen_b1_d = 1'b0;
        wen_b2_d = 1'b0;
        sel_d    = sel_q;
        dv_d     = dv_q;
        swap_d   = 1'b0;
        drop_d   = drop_q;

        case (state_q)
            S_IDLE: begin
                if (init) state_d = S_FILL;
            end
            S_FILL: begin
                // A boundary during a fill leaves the front bank in place and is counted.
                if (rd_frame_start && (drop_q != '1))
                    drop_d = drop_q + DROP_W'(1);
                if (xfer) begin
                    // Back bank is the one the display is not reading.
                    wen_b1_d = sel_q;
                    wen_b2_d = ~sel_q;
                    addr_d   = cnt_q;
                    data_d   = wr.wr_data;
                    if (cnt_q == LAST_PIX) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        cnt_d = cnt_q + ADDR_W'(1);
                    end
                end
            end
            S_WAIT: begin
                if (rd_frame_start) begin
                    sel_d   = ~sel_q;
                    dv_d    = 1'b1;
                    swap_d  = 1'b1;
                    state_d = S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_40 or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= 1'b0;
            wen_b1_q <= 1'b0;
            wen_b2_q <= 1'b0;
            sel_q    <= 1'b1;
            dv_q     <= 1'b0;
            swap_q   <= 1'b0;
            drop_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            wen_b1_q <= wen_b1_d;
            wen_b2_q <= wen_b2_d;
            sel_q    <= sel_d;
            dv_q     <= dv_d;
            swap_q   <= swap_d;
            drop_q   <= drop_d;
        end
    end

    assign wr_en_b1       = wen_b1_q;
    assign wr_en_b2       = wen_b2_q;
    assign wr_addr        = addr_q;
    assign wr_data_q      = data_q;
    assign rd_bank_sel    = sel_q;
    assign display_valid  = dv_q;
    assign frame_swap     = swap_q;
    assign dropped_frames = drop_q;

endmodule

// File: tb/tb_frame_bank_scheduler.sv
// Scoreboard bench for frame_bank_scheduler: directed stimulus pushes expected
// bank writes and swaps; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_frame_bank_scheduler;

    localparam int PPF = 1280;

    logic        CLK_40 = 1'b0;
    logic        reset;
    logic        init;
    logic        rd_frame_start;
    logic        wr_en_b1, wr_en_b2;
    logic [10:0] wr_addr;
    logic        wr_data_q;
    logic        rd_bank_sel;
    logic        display_valid;
    logic        frame_swap;
    logic [7:0]  dropped_frames;

    frame_bank_if wr_if();

    frame_bank_scheduler #(.PIXELS_PER_FRAME(PPF), .ADDR_W(11), .DROP_W(8)) dut (
        .CLK_40         (CLK_40),
        .reset          (reset),
        .init           (init),
        .wr             (wr_if),
        .rd_frame_start (rd_frame_start),
        .wr_en_b1       (wr_en_b1),
        .wr_en_b2       (wr_en_b2),
        .wr_addr        (wr_addr),
        .wr_data_q      (wr_data_q),
        .rd_bank_sel    (rd_bank_sel),
        .display_valid  (display_valid),
        .frame_swap     (frame_swap),
        .dropped_frames (dropped_frames)
    );

    always #5 CLK_40 = ~CLK_40;

    int n_cmp = 0;
    int n_bad = 0;

    logic [13:0] wq[$];   // {wr_en_b1, wr_en_b2, wr_addr, wr_data_q}
    logic [1:0]  sq[$];   // {rd_bank_sel, display_valid} seen with frame_swap

    typedef enum {M_IDLE, M_FILL, M_WAIT} mst_t;
    mst_t m_st;
    int   m_cnt;
    bit   m_sel;
    int   m_drop;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic bit pix(input int c);
        return c[0] ^ c[4];
    endfunction

    task automatic model_reset();
        m_st = M_IDLE; m_cnt = 0; m_sel = 1'b1; m_drop = 0;
    endtask

    // One clock of stimulus; the model advances with what the DUT will sample.
    task automatic step(input bit v, input bit fs, input bit ini);
        init             = ini;
        rd_frame_start   = fs;
        wr_if.wr_valid   = v;
        wr_if.wr_data    = pix(m_cnt);
        case (m_st)
            M_IDLE: if (ini) m_st = M_FILL;
            M_FILL: begin
                if (fs && m_drop < 255) m_drop++;
                if (v) begin
                    wq.push_back({m_sel, ~m_sel, 11'(m_cnt), pix(m_cnt)});
                    if (m_cnt == PPF - 1) begin
                        m_cnt = 0;
                        m_st  = M_WAIT;
                    end else m_cnt++;
                end
            end
            M_WAIT: if (fs) begin
                m_sel = ~m_sel;
                sq.push_back({m_sel, 1'b1});
                m_st = M_FILL;
            end
            default: ;
        endcase
        @(posedge CLK_40); #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_wr_en_b1"}, wr_en_b1, 0);
        check({tag, "_wr_en_b2"}, wr_en_b2, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data_q"}, wr_data_q, 0);
        check({tag, "_rd_bank_sel"}, rd_bank_sel, 1);
        check({tag, "_display_valid"}, display_valid, 0);
        check({tag, "_frame_swap"}, frame_swap, 0);
        check({tag, "_dropped"}, dropped_frames, 0);
        check({tag, "_wr_ready"}, wr_if.wr_ready, 0);
    endtask

    // Monitor: every write strobe and swap pulse must match the next queued expectation.
    always @(negedge CLK_40) begin
        if (reset) begin
            if (wr_en_b1 && wr_en_b2) check("both_wen", 1, 0);
            if (wr_en_b1 || wr_en_b2) begin
                if (wq.size() == 0) check("unexpected_write", {wr_en_b1, wr_en_b2, wr_addr}, 0);
                else check("write", {wr_en_b1, wr_en_b2, wr_addr, wr_data_q}, wq.pop_front());
            end
            if (frame_swap) begin
                if (sq.size() == 0) check("unexpected_swap", 1, 0);
                else check("swap", {rd_bank_sel, display_valid}, sq.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        n_bad++;
        $display("FAIL watchdog: time limit expired");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; init = 1'b1; rd_frame_start = 1'b0;
        wr_if.wr_valid = 1'b0; wr_if.wr_data = 1'b0;
        model_reset();
        repeat (3) @(posedge CLK_40);
        #1;
        check_reset_vals("por");
        init = 1'b0; reset = 1'b1;
        step(0, 1, 0);                        // boundary in IDLE is ignored
        step(0, 0, 0);
        check("idle_dropped", dropped_frames, 0);
        check("idle_ready", wr_if.wr_ready, 0);

        // Partial fill, then reset mid-frame.
        step(0, 0, 1);
        check("init_ready", wr_if.wr_ready, 1);
        for (int i = 0; i < 100; i++) step(1, 0, 0);
        step(0, 0, 0);
        reset = 1'b0; init = 1'b1;
        #1;
        check_reset_vals("mid");
        model_reset();
        repeat (2) @(posedge CLK_40);
        #1;
        init = 1'b0; reset = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        check("post_reset_ready", wr_if.wr_ready, 0);

        // Full frame into bank 1.
        step(0, 0, 1);
        for (int i = 0; i < PPF; i++) step(1, 0, 0);
        check("wait_ready", wr_if.wr_ready, 0);
        step(1, 0, 0);                        // valid while waiting must not write
        step(0, 0, 0);

        // Swap: bank 2 becomes the back bank.
        step(0, 1, 0);
        step(0, 0, 0);
        check("swap_sel", rd_bank_sel, 0);
        check("swap_dv", display_valid, 1);
        check("swap_ready", wr_if.wr_ready, 1);
        check("swap_dropped", dropped_frames, 0);

        for (int i = 0; i < 10; i++) step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0);
            step(0, 0, 1);                    // init outside IDLE is ignored
        end
        check("three_drops", dropped_frames, 3);
        check("drop_sel", rd_bank_sel, 0);

        // Rest of frame; final pixel coincides with a boundary.
        for (int i = 10; i < PPF - 1; i++) step(1, 0, 0);
        step(1, 1, 0);
        step(0, 0, 0);
        check("coincide_dropped", dropped_frames, 4);
        check("coincide_sel", rd_bank_sel, 0);
        check("coincide_ready", wr_if.wr_ready, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        check("second_swap_sel", rd_bank_sel, 1);

        // Saturation of the dropped-frame counter.
        for (int i = 0; i < 251; i++) step(0, 1, 0);
        check("sat_reach", dropped_frames, 255);
        for (int i = 0; i < 49; i++) step(0, 1, 0);
        check("sat_hold", dropped_frames, 255);
        check("sat_model", dropped_frames, m_drop);

        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        check("write_queue_empty", wq.size(), 0);
        check("swap_queue_empty", sq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
